vec_alu_seq: RTL

Sequencer for the modular vector ALU. It accepts one vector command at a time (opcode, two source base addresses, destination base, length, modulus q and Barrett constant mu). It streams element pairs out of the vector scratchpad's two synchronous read ports, drives the combinational ALU, and writes each result back through the scratchpad's write port. It sits between the NTT/VM instruction decoder (command side) and the scratchpad plus ALU (datapath side).

---
 rtl/vec_ctrl_pkg.sv | 31 +++
 rtl/vec_alu_seq_if.sv | 53 +++++
 rtl/vec_addr_gen.sv | 42 ++++
 rtl/vec_alu_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vec_ctrl_pkg.sv
// Shared control definitions for the modular vector ALU block.
// Holds the opcode constants (also used by the decoder and the ALU),
// the sequencer FSM state encoding and the read-to-write drain depth.
package vec_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;

  // Cycles between the last read issue and completion: data return + write.
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Per-command ALU configuration, held constant for the whole command.
  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] q;
    logic [63:0] mu;
  } alu_cfg_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/vec_alu_seq_if.sv
// Bus bundle of the vector ALU sequencer: command handshake from the decoder,
// scratchpad read/write ports, ALU operand/result wires and status.
// slave  : the sequencer side.
// master : the environment side (decoder, scratchpad, ALU).
interface vec_alu_seq_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
);
  // command
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_src_a;
  logic [ADDR_W-1:0] cmd_src_b;
  logic [ADDR_W-1:0] cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic [63:0]       cmd_q;
  logic [63:0]       cmd_mu;
  // scratchpad
  logic              rd_en;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [63:0]       rd_a_data;
  logic [63:0]       rd_b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  // ALU
  logic [2:0]        alu_opcode;
  logic [63:0]       alu_op_a;
  logic [63:0]       alu_op_b;
  logic [63:0]       alu_q;
  logic [63:0]       alu_mu;
  logic [63:0]       alu_res;
  // status
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, cmd_q, cmd_mu,
    input  rd_a_data, rd_b_data, alu_res,
    output cmd_ready, rd_en, rd_a_addr, rd_b_addr, wr_en, wr_addr, wr_data,
    output alu_opcode, alu_op_a, alu_op_b, alu_q, alu_mu, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, cmd_q, cmd_mu,
    output rd_a_data, rd_b_data, alu_res,
    input  cmd_ready, rd_en, rd_a_addr, rd_b_addr, wr_en, wr_addr, wr_data,
    input  alu_opcode, alu_op_a, alu_op_b, alu_q, alu_mu, busy, done, err
  );
endinterface

// File: rtl/vec_addr_gen.sv
// Element counter and address generation for the vector sequencer.
// clk_i/rst_n  : clock, async active-low reset
// start_i      : clear the counter (command accept)
// step_i       : advance one element (a read is issued this cycle)
// len_i        : latched vector length (nonzero while stepping)
// src_a_i/src_b_i/dst_i : latched base addresses
// rd_a_addr_o/rd_b_addr_o/dst_addr_o : base + i, modulo 2^ADDR_W
// last_o       : current element is the final one
module vec_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] src_a_i,
  input  logic [ADDR_W-1:0] src_b_i,
  input  logic [ADDR_W-1:0] dst_i,
  output logic [ADDR_W-1:0] rd_a_addr_o,
  output logic [ADDR_W-1:0] rd_b_addr_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic              last_o
);
  logic [LEN_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] idx;

  // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap for free.
  assign idx         = cnt_q[ADDR_W-1:0];
  assign rd_a_addr_o = src_a_i + idx;
  assign rd_b_addr_o = src_b_i + idx;
  assign dst_addr_o  = dst_i + idx;
  assign last_o      = (cnt_q == len_i - LEN_W'(1));

  // Counter parks at 0 after the last element so the next command starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (start_i) cnt_q <= '0;
    else if (step_i)  cnt_q <= last_o ? '0 : cnt_q + LEN_W'(1);
  end
endmodule

// File: rtl/vec_alu_seq.sv
// Vector ALU sequencer: accepts one command, streams element pairs from the
// scratchpad read ports through the combinational ALU and writes results back.
// clk/rst_n : clock, async active-low reset
// bus       : command handshake, scratchpad ports, ALU wires, busy/done/err
// Pipeline: read issue (i) -> data/ALU (i+1) -> registered write (i+2).
module vec_alu_seq
  import vec_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input logic           clk,
  input logic           rst_n,
  vec_alu_seq_if.slave  bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  seq_state_e        state_q;
  alu_cfg_t          cfg_q;
  logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
  logic [LEN_W-1:0]  len_q;
  logic              ready_q, busy_q, rd_en_q, done_q, err_q;
  logic [DW-1:0]     drain_q;

  // vld_pipe[0]: read data valid this cycle, vld_pipe[1]: write this cycle
  logic [1:0]        vld_pipe;
  logic [ADDR_W-1:0] d1_addr_q, wr_addr_q;
  logic [63:0]       wr_data_q;

  logic [ADDR_W-1:0] dst_addr;
  logic              last, accept;

  assign accept = bus.cmd_valid && ready_q;

  vec_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (accept),
    .step_i     (rd_en_q),
    .len_i      (len_q),
    .src_a_i    (src_a_q),
    .src_b_i    (src_b_q),
    .dst_i      (dst_q),
    .rd_a_addr_o(bus.rd_a_addr),
    .rd_b_addr_o(bus.rd_b_addr),
    .dst_addr_o (dst_addr),
    .last_o     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drain_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (accept) begin
          cfg_q   <= '{op: bus.cmd_op, q: bus.cmd_q, mu: bus.cmd_mu};
          src_a_q <= bus.cmd_src_a;
          src_b_q <= bus.cmd_src_b;
          dst_q   <= bus.cmd_dst;
          len_q   <= bus.cmd_len;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          // Empty or illegal commands skip straight to completion.
          if (bus.cmd_len == '0 || !op_legal(bus.cmd_op)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            err_q   <= !op_legal(bus.cmd_op);
          end else begin
            state_q <= ST_ISSUE;
            rd_en_q <= 1'b1;
          end
        end
        ST_ISSUE: if (last) begin
          rd_en_q <= 1'b0;
          drain_q <= '0;
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write stage: the destination address travels alongside the read data so
  // the element written always matches the element read two cycles earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      d1_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0], rd_en_q};
      d1_addr_q <= dst_addr;
      if (vld_pipe[0]) begin
        wr_addr_q <= d1_addr_q;
        wr_data_q <= bus.alu_res;
      end
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.wr_en      = vld_pipe[1];
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.alu_opcode = cfg_q.op;
  assign bus.alu_q      = cfg_q.q;
  assign bus.alu_mu     = cfg_q.mu;
  assign bus.alu_op_a   = bus.rd_a_data;
  assign bus.alu_op_b   = bus.rd_b_data;
endmodule
